approx_mul_pipe: RTL

- Parametrised, pipelined successor to the fixed 8x8 half-adder-array approximate multiplier.
- Operands arrive on a valid/ready stream. Partial-product rows are paired and compressed per column in one of three modes: truncate, OR-sum or exact HA. The pair results are then summed.
- The compression mode is selected per beat by two column thresholds that travel with the data.
- The block also computes the exact product, reports the error per beat and keeps a saturating count of erroneous beats. It sits between the operand source and the approximation-quality monitor.

---
 rtl/approx_mul_pkg.sv | 30 +++
 rtl/approx_pair_compress.sv | 44 ++++
 rtl/approx_mul_pipe.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/approx_mul_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
package approx_mul_pkg;

    // How one column of a row pair is compressed.
    typedef enum logic [1:0] {
        COL_ELIM = 2'd0,
        COL_OR   = 2'd1,
        COL_HA   = 2'd2
    } col_mode_e;

    // Threshold fields must be able to express every column index 0..2*WIDTH.
    function automatic int cw_of(input int width);
        return $clog2(2 * width + 1);
    endfunction

    // Mode of global column g for a given pair of thresholds. An OR threshold
    // at or below the truncation threshold simply never matches.
    function automatic col_mode_e col_mode(input int unsigned g,
                                           input int unsigned trunc_cols,
                                           input int unsigned or_cols);
        if (g < trunc_cols) begin
            return COL_ELIM;
        end
        if (g < or_cols) begin
            return COL_OR;
        end
        return COL_HA;
    endfunction

endpackage

// File: rtl/approx_pair_compress.sv
// Combinational compressor for partial-product rows 2K and 2K+1.
// Column j of the pair sits at global column j+2K; row 2K contributes
// y[j] and row 2K+1 contributes y[j-1], so the pair spans WIDTH+1 columns.
module approx_pair_compress
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K     = 0,
    parameter int CW    = cw_of(WIDTH)
) (
    input  logic [1:0]       x_pair_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [CW-1:0]    trunc_cols_i,
    input  logic [CW-1:0]    or_cols_i,
    output logic [WIDTH:0]   sum_o,
    output logic [WIDTH:0]   carry_o
);

    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_col
        logic      a;
        logic      b;
        col_mode_e mode;

        if (gi < WIDTH) begin : g_a
            assign a = y_i[gi] & x_pair_i[0];
        end else begin : g_a_top
            assign a = 1'b0;
        end

        if (gi >= 1) begin : g_b
            assign b = y_i[gi-1] & x_pair_i[1];
        end else begin : g_b_low
            assign b = 1'b0;
        end

        assign mode = col_mode(32'(gi + 2 * K), 32'(trunc_cols_i), 32'(or_cols_i));

        // Eliminated columns drop both bits; OR columns lose the a&b carry.
        assign sum_o[gi]   = (mode == COL_OR) ? (a | b) :
                             (mode == COL_HA) ? (a ^ b) : 1'b0;
        assign carry_o[gi] = (mode == COL_HA) & a & b;
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Two-stage valid/ready approximate multiplier with exact-product error
// reporting and a saturating count of erroneous results.
// WIDTH must be even and at least 4.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int  WIDTH     = 8,
    parameter int  ERR_CNT_W = 16,
    localparam int CW        = cw_of(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_x,
    input  logic [WIDTH-1:0]     in_y,
    input  logic [CW-1:0]        in_trunc_cols,
    input  logic [CW-1:0]        in_or_cols,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic [2*WIDTH-1:0]   out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_cnt_clr
);

    localparam int NP = WIDTH / 2;
    localparam int PW = 2 * WIDTH;

    // ---------------- combinational front end ----------------
    logic [WIDTH:0] sum_c   [NP];
    logic [WIDTH:0] carry_c [NP];
    logic [PW-1:0]  exact_c;

    for (genvar gi = 0; gi < NP; gi++) begin : g_pair
        approx_pair_compress #(
            .WIDTH (WIDTH),
            .K     (gi),
            .CW    (CW)
        ) u_pair (
            .x_pair_i     (in_x[2*gi+1 -: 2]),
            .y_i          (in_y),
            .trunc_cols_i (in_trunc_cols),
            .or_cols_i    (in_or_cols),
            .sum_o        (sum_c[gi]),
            .carry_o      (carry_c[gi])
        );
    end

    assign exact_c = PW'(in_x) * PW'(in_y);

    // ---------------- handshake ----------------
    logic s1_valid_q, s1_valid_d;
    logic out_valid_q, out_valid_d;
    logic s2_can_load;
    logic s1_load;
    logic s2_load;
    logic consume;

    // in_ready depends only on registered state and out_ready, never on in_valid.
    assign s2_can_load = !out_valid_q | out_ready;
    assign in_ready    = !s1_valid_q | s2_can_load;
    assign s1_load     = in_valid & in_ready;
    assign s2_load     = s1_valid_q & s2_can_load;
    assign consume     = out_valid_q & out_ready;

    // Each stage refills whenever it is able to load; otherwise it holds.
    assign s1_valid_d  = in_ready    ? in_valid   : s1_valid_q;
    assign out_valid_d = s2_can_load ? s1_valid_q : out_valid_q;

    // Valid bits are the only state that needs a clean reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ---------------- stage 1 data ----------------
    logic [WIDTH:0] s1_sum_q   [NP];
    logic [WIDTH:0] s1_carry_q [NP];
    logic [PW-1:0]  s1_exact_q;

    // Stage 1 captures pair vectors and the exact product only on a load.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            for (int k = 0; k < NP; k++) begin
                s1_sum_q[k]   <= sum_c[k];
                s1_carry_q[k] <= carry_c[k];
            end
            s1_exact_q <= exact_c;
        end
    end

    // ---------------- stage 2 reduction ----------------
    logic [PW-1:0] pair_val;
    logic [PW-1:0] approx_d;
    logic [PW-1:0] err_d;

    // Weight each pair by its row offset and accumulate modulo 2^(2*WIDTH).
    always_comb begin
        pair_val = '0;
        approx_d = '0;
        for (int k = 0; k < NP; k++) begin
            pair_val = PW'(s1_sum_q[k]) + (PW'(s1_carry_q[k]) << 1);
            approx_d = approx_d + (pair_val << (2 * k));
        end
    end

    // Approximation only ever drops weight, so this difference never wraps.
    assign err_d = s1_exact_q - approx_d;

    logic [PW-1:0] out_prod_q;
    logic [PW-1:0] out_err_q;

    // Output registers change only when a new result moves in, so they hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_prod_q <= '0;
            out_err_q  <= '0;
        end else if (s2_load) begin
            out_prod_q <= approx_d;
            out_err_q  <= err_d;
        end
    end

    // ---------------- error-beat counter ----------------
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Clear wins over a same-cycle increment; counting stops at all ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_cnt_clr) begin
            err_cnt_d = '0;
        end else if (consume && (out_err_q != '0) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule
